// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg: shared types and constants for the AES128 job scheduler.
//   sched_state_t        - scheduler FSM states (IDLE, LAUNCH, WAIT, RESPOND)
//   AES_BLOCK_W          - AES block width in bits
//   AES_KEY_W            - AES key width in bits
//   DEFAULT_CORE_LATENCY - start-to-result latency of the attached AES128 core
package aes_sched_pkg;

    localparam int AES_BLOCK_W          = 128;
    localparam int AES_KEY_W            = 128;
    localparam int DEFAULT_CORE_LATENCY = 11;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESPOND
    } sched_state_t;

endpackage

// File: rtl/aes_job_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req_i - request vector, one bit per requester
//   ptr_i - highest-priority requester index; search runs upward from here with wrap
//   gnt_o - one-hot grant (all zero when no request)
//   idx_o - index of the granted requester (0 when no request)
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int IW = $clog2(N);

    logic          found;
    logic [IW-1:0] j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler: round-robin arbitration and sequencing of a shared AES128 core.
//   clk_i             - system clock, rising edge
//   rst_ni            - asynchronous active-low reset
//   req_valid_i       - per-requester job valid
//   req_ready_o       - per-requester job accept (only while idle, at most one bit)
//   req_sel_cypher_i  - per-requester mode, 1 = encrypt, 0 = decrypt
//   req_key_i         - per-requester key, requester i at [i*128 +: 128]
//   req_msg_i         - per-requester input block, same slicing
//   rsp_valid_o       - per-requester result valid (one-hot or zero)
//   rsp_ready_i       - per-requester result accept
//   rsp_data_o        - result block shared by all requesters
//   core_start_o      - one-cycle start pulse to the core
//   core_sel_cypher_o - mode to the core
//   core_key_o        - key to the core
//   core_msg_o        - block to the core
//   core_result_i     - core output block
//   busy_o            - high whenever not idle
//   job_count_o       - completed-job counter, wraps
module aes_job_scheduler
    import aes_sched_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int CORE_LATENCY = DEFAULT_CORE_LATENCY,
    parameter int CNT_W        = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N_REQ-1:0]             req_valid_i,
    output logic [N_REQ-1:0]             req_ready_o,
    input  logic [N_REQ-1:0]             req_sel_cypher_i,
    input  logic [N_REQ*AES_KEY_W-1:0]   req_key_i,
    input  logic [N_REQ*AES_BLOCK_W-1:0] req_msg_i,
    output logic [N_REQ-1:0]             rsp_valid_o,
    input  logic [N_REQ-1:0]             rsp_ready_i,
    output logic [AES_BLOCK_W-1:0]       rsp_data_o,
    output logic                         core_start_o,
    output logic                         core_sel_cypher_o,
    output logic [AES_KEY_W-1:0]         core_key_o,
    output logic [AES_BLOCK_W-1:0]       core_msg_o,
    input  logic [AES_BLOCK_W-1:0]       core_result_i,
    output logic                         busy_o,
    output logic [CNT_W-1:0]             job_count_o
);

    localparam int IW = $clog2(N_REQ);
    localparam int LW = $clog2(CORE_LATENCY + 1);

    if (N_REQ < 2) begin : g_chk_nreq
        $error("aes_job_scheduler: N_REQ must be at least 2");
    end
    if (CORE_LATENCY < 1) begin : g_chk_lat
        $error("aes_job_scheduler: CORE_LATENCY must be at least 1");
    end

    sched_state_t           state_q, state_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [IW-1:0]          gidx_q, gidx_d;
    logic [LW-1:0]          cnt_q, cnt_d;
    logic [AES_KEY_W-1:0]   key_q, key_d;
    logic [AES_BLOCK_W-1:0] msg_q, msg_d;
    logic                   sel_q, sel_d;
    logic [AES_BLOCK_W-1:0] rsp_q, rsp_d;
    logic [CNT_W-1:0]       jobs_q, jobs_d;

    logic [N_REQ-1:0]       arb_gnt;
    logic [IW-1:0]          arb_idx;

    rr_arbiter #(
        .N(N_REQ)
    ) u_arb (
        .req_i(req_valid_i),
        .ptr_i(ptr_q),
        .gnt_o(arb_gnt),
        .idx_o(arb_idx)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            cnt_q   <= '0;
            key_q   <= '0;
            msg_q   <= '0;
            sel_q   <= 1'b0;
            rsp_q   <= '0;
            jobs_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            msg_q   <= msg_d;
            sel_q   <= sel_d;
            rsp_q   <= rsp_d;
            jobs_q  <= jobs_d;
        end
    end

    // The core result is only ever sampled in WAIT, so output from a job
    // abandoned by reset simply goes unobserved.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        msg_d   = msg_q;
        sel_d   = sel_q;
        rsp_d   = rsp_q;
        jobs_d  = jobs_q;
        unique case (state_q)
            IDLE: begin
                // Ready mirrors the grant, so any valid request is a handshake
                // on the granted requester.
                if (|req_valid_i) begin
                    gidx_d  = arb_idx;
                    key_d   = req_key_i[arb_idx*AES_KEY_W +: AES_KEY_W];
                    msg_d   = req_msg_i[arb_idx*AES_BLOCK_W +: AES_BLOCK_W];
                    sel_d   = req_sel_cypher_i[arb_idx];
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = LW'(CORE_LATENCY);
                state_d = WAIT;
            end
            WAIT: begin
                // Counter reads CORE_LATENCY in the first WAIT cycle, so the
                // count of 1 marks the cycle the core result becomes valid.
                cnt_d = cnt_q - LW'(1);
                if (cnt_q == LW'(1)) begin
                    rsp_d   = core_result_i;
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                if (rsp_ready_i[gidx_q]) begin
                    jobs_d  = jobs_q + CNT_W'(1);
                    ptr_d   = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + IW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated by reset so requesters see no accept while the block is held in reset.
    assign req_ready_o       = (state_q == IDLE && rst_ni) ? arb_gnt : '0;
    assign rsp_valid_o       = (state_q == RESPOND) ? (N_REQ'(1) << gidx_q) : '0;
    assign rsp_data_o        = rsp_q;
    assign core_start_o      = (state_q == LAUNCH);
    assign core_sel_cypher_o = sel_q;
    assign core_key_o        = key_q;
    assign core_msg_o        = msg_q;
    assign busy_o            = (state_q != IDLE);
    assign job_count_o       = jobs_q;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// tb_aes_job_scheduler: self-checking bench with a latency-accurate stand-in AES core.
module tb_aes_job_scheduler;

    localparam int N = 2;
    localparam int L = 11;
    localparam int W = 4;
    localparam logic [127:0] K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] rsp_ready = '0;
    logic [N-1:0] sel_r = '0;
    logic [127:0] key_r [N] = '{default: '0};
    logic [127:0] msg_r [N] = '{default: '0};
    logic [127:0] core_result = '0;

    logic [N-1:0] req_ready, rsp_valid;
    logic [127:0] rsp_data, core_key, core_msg;
    logic core_start, core_sel, busy;
    logic [W-1:0] job_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int s_cyc = -1000;
    int ptr_m = 0;
    int jobs_m = 0;
    logic [127:0] m_key = '0, m_msg = '0;
    logic m_sel = 1'b0;

    always #5 clk = ~clk;

    aes_job_scheduler #(.N_REQ(N), .CORE_LATENCY(L), .CNT_W(W)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_sel_cypher_i(sel_r),
        .req_key_i({key_r[1], key_r[0]}),
        .req_msg_i({msg_r[1], msg_r[0]}),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data),
        .core_start_o(core_start),
        .core_sel_cypher_o(core_sel),
        .core_key_o(core_key),
        .core_msg_o(core_msg),
        .core_result_i(core_result),
        .busy_o(busy),
        .job_count_o(job_count)
    );

    // Stand-in for AES128: known FIPS-197 answers, an arbitrary mix otherwise.
    function automatic logic [127:0] ref_core(input logic [127:0] k, input logic [127:0] m, input logic s);
        if (k == K && s && m == P) return C;
        if (k == K && !s && m == C) return P;
        return s ? (k ^ {m[63:0], m[127:64]}) : ~(k + m);
    endfunction

    function automatic int first_valid(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        return (i < 0) ? '0 : (N'(1) << i);
    endfunction

    // Result is valid only in cycle S+L; any other cycle carries noise.
    always @(posedge clk) begin
        if (core_start) begin
            s_cyc = cyc;
            m_key = core_key;
            m_msg = core_msg;
            m_sel = core_sel;
        end
        core_result <= (cyc + 1 == s_cyc + L) ? ref_core(m_key, m_msg, m_sel)
                                              : {$urandom, $urandom, $urandom, $urandom};
        cyc++;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            chk("rdy_onehot", $countones(req_ready) <= 1, 1);
            chk("rdy_while_busy", busy && req_ready != 0, 0);
            chk("rsp_onehot", $countones(rsp_valid) <= 1, 1);
        end
    end

    task automatic chk_zero(input string nm);
        chk({nm, "_req_ready"}, req_ready, 0);
        chk({nm, "_rsp_valid"}, rsp_valid, 0);
        chk({nm, "_rsp_data"}, rsp_data, 0);
        chk({nm, "_core_start"}, core_start, 0);
        chk({nm, "_core_sel"}, core_sel, 0);
        chk({nm, "_core_key"}, core_key, 0);
        chk({nm, "_core_msg"}, core_msg, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_job_count"}, job_count, 0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Runs one job from accept to response handshake; call just after a negedge
    // with inputs applied (or in the idle cycle right after a previous job).
    task automatic do_job(input int stall, input bit keep, output int g, output logic [127:0] d, output int cnt);
        int a, s_at, starts, eg;
        bit got;
        logic [127:0] ek, em, ed;
        logic es;
        g = -1;
        d = '0;
        cnt = -1;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (req_ready != 0) break;
            @(negedge clk);
        end
        chk("accept_seen", req_ready != 0, 1);
        if (req_ready == 0) return;
        eg = first_valid(req_valid, ptr_m);
        chk("grant", req_ready, oh(eg));
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        a = cyc;
        ek = key_r[g];
        em = msg_r[g];
        es = sel_r[g];
        ed = ref_core(ek, em, es);
        starts = 0;
        s_at = -1;
        got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (n == 0 && !keep) req_valid = '0;
            #1;
            if (core_start) begin
                starts++;
                s_at = cyc;
                chk("core_key", core_key, ek);
                chk("core_msg", core_msg, em);
                chk("core_sel", core_sel, es);
            end
            got = (rsp_valid != 0);
        end
        chk("rsp_seen", got, 1);
        if (!got) return;
        chk("core_start_once", starts, 1);
        chk("start_cycle", s_at, a + 1);
        chk("rsp_cycle", cyc, a + L + 2);
        chk("rsp_valid", rsp_valid, oh(g));
        chk("rsp_data", rsp_data, ed);
        chk("core_key_hold", core_key, ek);
        chk("busy_resp", busy, 1);
        d = rsp_data;
        rsp_ready = ~oh(g);
        for (int n = 0; n < stall; n++) begin
            @(negedge clk);
            #1;
            chk("stall_data", rsp_data, d);
            chk("stall_valid", rsp_valid, oh(g));
            chk("stall_ready", req_ready, 0);
        end
        rsp_ready = oh(g);
        @(negedge clk);
        rsp_ready = '0;
        #1;
        ptr_m = (g + 1) % N;
        jobs_m++;
        chk("rsp_drop", rsp_valid, 0);
        chk("busy_idle", busy, 0);
        chk("job_count", job_count, jobs_m % (1 << W));
        chk("rsp_hold", rsp_data, d);
        chk("re_accept", req_ready, oh(first_valid(req_valid, ptr_m)));
        cnt = job_count;
    endtask

    typedef struct {
        logic [1:0]   mask;
        logic         sel;
        logic [127:0] key;
        logic [127:0] msg;
        int           stall;
        int           exp_g;
        logic [127:0] exp_d;
    } vec_t;

    initial begin
        vec_t tv[4];
        int g, c, a, seen;
        int cnts[16];
        logic [127:0] d, k2, m2, m3;

        repeat (2) @(negedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        k2 = rnd128();
        m2 = rnd128();
        m3 = rnd128();
        tv[0] = '{2'b01, 1'b1, K, P, 0, 0, C};
        tv[1] = '{2'b10, 1'b0, K, C, 3, 1, P};
        tv[2] = '{2'b11, 1'b1, k2, m2, 1, 0, ref_core(k2, m2, 1'b1)};
        tv[3] = '{2'b11, 1'b0, k2, m3, 0, 1, ref_core(k2, m3, 1'b0)};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            key_r[0] = tv[i].key;
            key_r[1] = tv[i].key;
            msg_r[0] = tv[i].msg;
            msg_r[1] = tv[i].msg;
            sel_r = {N{tv[i].sel}};
            req_valid = tv[i].mask;
            do_job(tv[i].stall, 1'b0, g, d, c);
            chk("tv_grant", g, tv[i].exp_g);
            chk("tv_data", d, tv[i].exp_d);
            chk("tv_count", c, i + 1);
        end

        // Contention: both requesters held valid, alternating grants.
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            key_r[i] = rnd128();
            msg_r[i] = rnd128();
        end
        sel_r = 2'b01;
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            do_job(0, j < 3, g, d, c);
            chk("contend_order", g, j % 2);
        end

        // Backpressure on requester 0 while requester 1 keeps asking.
        @(negedge clk);
        req_valid = 2'b11;
        do_job(20, 1'b1, g, d, c);
        chk("bp_first", g, 0);
        do_job(0, 1'b0, g, d, c);
        chk("bp_second", g, 1);

        // A valid that drops before its handshake commits nothing.
        @(negedge clk);
        req_valid = 2'b01;
        #1;
        chk("drop_ready", req_ready, 2'b01);
        #2;
        req_valid = '0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("drop_no_job", busy || core_start, 0);
        end

        @(negedge clk);
        req_valid = 2'b01;
        do_job(0, 1'b0, g, d, c);
        chk("pre_rst_grant", g, 0);

        // Reset in the middle of a job on requester 1.
        @(negedge clk);
        key_r[1] = K;
        msg_r[1] = P;
        sel_r[1] = 1'b1;
        req_valid = 2'b10;
        a = -1;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (req_ready[1]) begin
                a = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("rst_accept", a >= 0, 1);
        @(negedge clk);
        req_valid = '0;
        while (cyc < a + 6) @(negedge clk);
        #1;
        chk("rst_in_wait", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        jobs_m = 0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (rsp_valid != 0 || busy || core_start) seen++;
        end
        chk("rst_no_rsp", seen, 0);
        @(negedge clk);
        key_r[0] = K;
        key_r[1] = K;
        msg_r[0] = P;
        msg_r[1] = P;
        sel_r = 2'b11;
        req_valid = 2'b11;
        do_job(0, 1'b0, g, d, c);
        chk("post_rst_grant", g, 0);
        chk("post_rst_data", d, C);
        chk("post_rst_count", c, 1);

        // Counter wrap: 16 more jobs give 17 since reset.
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            key_r[j % 2] = rnd128();
            msg_r[j % 2] = rnd128();
            sel_r[j % 2] = 1'($urandom);
            req_valid = oh(j % 2);
            do_job(0, 1'b0, g, d, c);
            cnts[j] = c;
        end
        chk("wrap_15", cnts[13], 15);
        chk("wrap_0", cnts[14], 0);
        chk("wrap_1", cnts[15], 1);

        // Random traffic against the model.
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                key_r[i] = rnd128();
                msg_r[i] = rnd128();
            end
            sel_r = 2'($urandom);
            req_valid = 2'($urandom_range(1, 3));
            do_job($urandom_range(0, 3), 1'b0, g, d, c);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_job_scheduler.md
Name: aes_job_scheduler

Overview:
- Sequences the shared AES128 core and arbitrates it between N_REQ independent requesters, such as the bus interface and a stream/DMA port.
- Each requester submits one job (key, 128-bit block, encrypt/decrypt select) through a valid/ready handshake.
- The scheduler grants jobs round-robin, launches the core with a one-cycle start pulse, and waits a fixed core latency.
- It then returns the result to the granted requester through a valid/ready response handshake.

Parameters:
- N_REQ, 2, number of requesters (>=2).
- CORE_LATENCY, 11, cycles from the core_start cycle to core_result valid (>=1; elaboration-time assertion).
- CNT_W, 16, width of the completed-job counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester job valid.
- req_ready  out  N_REQ  per-requester job accept.
- req_sel_cypher  in  N_REQ  per-requester mode: 1 = encrypt, 0 = decrypt.
- req_key  in  N_REQ*128  per-requester key; requester i occupies slice [i*128 +: 128].
- req_msg  in  N_REQ*128  per-requester input block, same slicing.
- rsp_valid  out  N_REQ  per-requester result valid (one-hot or zero).
- rsp_ready  in  N_REQ  per-requester result accept.
- rsp_data  out  128  result block, shared by all requesters, qualified by rsp_valid.
- core_start  out  1  one-cycle start pulse to AES128.
- core_sel_cypher  out  1  mode to AES128.
- core_key  out  128  key to AES128.
- core_msg  out  128  block to AES128.
- core_result  in  128  AES128 message_out.
- busy  out  1  high in every state except IDLE.
- job_count  out  CNT_W  completed jobs, wraps.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr pointer=0, latency counter=0, grant index=0.
  - All outputs 0, including rsp_data, core_key, core_msg and job_count.
- FSM: IDLE -> LAUNCH -> WAIT -> RESPOND -> IDLE.
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching from the rr pointer upward with wrap.
  - req_ready[g]=1 combinationally, all other bits 0; no request means all bits 0.
  - Handshake (req_valid[g] & req_ready[g]) in cycle A:
    - Register g, req_key[g], req_msg[g] and req_sel_cypher[g] into the core_* output registers.
    - Go to LAUNCH.
- LAUNCH (cycle A+1 = S):
  - core_start=1 for exactly this cycle.
  - Load counter = CORE_LATENCY; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When it reaches 0, i.e. on the edge ending cycle S+CORE_LATENCY, register core_result into rsp_data and go to RESPOND.
- RESPOND:
  - rsp_valid[g]=1 from cycle S+CORE_LATENCY+1 = A+CORE_LATENCY+2. Default: A+13.
  - Held until rsp_ready[g]=1.
  - On handshake: job_count+1, rr pointer = (g+1) mod N_REQ, go to IDLE.
  - No same-cycle re-accept: the next req_ready is 1 one cycle after the rsp handshake.
- Stability rules:
  - core_key, core_msg and core_sel_cypher hold from LAUNCH until the next accept.
  - rsp_data holds until the next WAIT capture.
- req_ready is 0 for every requester whenever busy=1.
- req_valid may drop before its handshake without consequence; no job is committed.
- Simultaneous valids: the rr pointer decides. The pointer changes only on rsp handshake, never on reset-free idle cycles.
- rsp_ready held low stalls in RESPOND indefinitely. rsp_data and rsp_valid stay stable; other requesters see req_ready=0.
- rsp_ready on a non-granted bit is ignored.
- job_count wraps from 2^CNT_W-1 to 0.
- Reset mid-operation:
  - Job abandoned immediately, no response, core_start low.
  - Counter and pointer cleared.
  - Any later core output is ignored.

Decomposition:
- Package aes_sched_pkg:
  - Enum sched_state_t {IDLE, LAUNCH, WAIT, RESPOND}.
  - Localparams AES_BLOCK_W=128 and AES_KEY_W=128.
  - Default CORE_LATENCY constant.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant and grant index; purely combinational.
  - Instantiated once.
- Everything else stays in aes_job_scheduler.

Test Plan:
- FIPS-197 single job on req 0:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, msg 00112233445566778899aabbccddeeff, sel=1, AES128 attached.
  - Required: rsp_valid[0] at A+13, rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, core_start high exactly 1 cycle, job_count=1.
- Decrypt round trip on req 1:
  - Stimulus: same key, msg 69c4e0d86a7b0430d8cdb78070b4c55a, sel=0.
  - Required: rsp_valid[1] only, rsp_data 00112233445566778899aabbccddeeff.
- Contention:
  - Stimulus: req_valid=2'b11 held for 4 jobs, rr pointer from reset=0.
  - Required: grant order 0,1,0,1; req_ready never has 2 bits set; no req_ready while busy.
- Response backpressure:
  - Stimulus: rsp_ready[0] low for 20 cycles after rsp_valid[0] rises, req_valid[1]=1 throughout.
  - Required: rsp_data stable, req_ready=0 throughout; req 1 accepted 1 cycle after the rsp handshake.
- Reset mid-job:
  - Stimulus: assert reset in WAIT at S+5, release 2 cycles later.
  - Required: all outputs 0 immediately, no rsp_valid ever for the aborted job, state IDLE, next job completes normally with the correct result.
- Counter wrap:
  - Stimulus: CNT_W=4, run 17 jobs.
  - Required: job_count sequence ends 15,0,1.
